energy_accumulator: RTL and testbench
=====================================

ENERGY_ACCUMULATOR -- requirements
Module: energy_accumulator

Interface
REQ-001 SHALL have parameter VECTOR_SIZE, default 256, meaning spin count and number of columns per energy evaluation.
REQ-002 SHALL have parameter J_ELEMENT_WIDTH, default 4, meaning unsigned J element width used by the upstream dot-product tree.
REQ-003 SHALL have parameter DOT_WIDTH, default J_ELEMENT_WIDTH+$clog2(VECTOR_SIZE)+1 (13), meaning signed width of dot_in.
REQ-004 SHALL have parameter ACC_WIDTH, default DOT_WIDTH+$clog2(VECTOR_SIZE) (21), meaning signed width of energy_out.
REQ-005 SHALL have port clk, input, 1, the single clock; all state is updated on its rising edge.
REQ-006 SHALL have port rst_n, input, 1, reset, asynchronous and active-low.
REQ-007 SHALL have port start, input, 1, one-cycle pulse that begins an evaluation and latches sigma.
REQ-008 SHALL have port sigma, input, VECTOR_SIZE, spin vector; bit=1 means +1, bit=0 means -1.
REQ-009 SHALL have port dot_valid, input, 1, qualifies dot_in; driven by the dot-product tree's start_out.
REQ-010 SHALL have port dot_in, input signed, DOT_WIDTH, dot product of column col_idx with sigma.
REQ-011 SHALL have port col_idx, output, $clog2(VECTOR_SIZE), index of the next column expected.
REQ-012 SHALL have port busy, output, 1, high while in state ACC.
REQ-013 SHALL have port energy_out, output signed, ACC_WIDTH, result of the last completed evaluation.
REQ-014 SHALL have port energy_valid, output, 1, one-cycle pulse marking a new energy_out.

Function
REQ-015 SHALL implement states IDLE, ACC and DONE, entering IDLE on reset.
REQ-016 SHALL, on start in any state, latch sigma into an internal register, clear the accumulator and col_idx, and enter ACC on the next edge.
REQ-017 SHALL, in ACC with dot_valid=1, add dot_in to the accumulator if the latched sigma[col_idx]=1, subtract it if 0, and increment col_idx.
REQ-018 SHALL sign-extend dot_in to ACC_WIDTH before add/subtract; no saturation is needed because ACC_WIDTH bounds 256*3840=983040.
REQ-019 SHALL hold accumulator and col_idx in ACC when dot_valid=0; arbitrary gaps between columns are legal.
REQ-020 SHALL, on the accepted dot_valid with col_idx=VECTOR_SIZE-1, enter DONE, load energy_out with the final sum, and wrap col_idx to 0.
REQ-021 SHALL assert energy_valid exactly in the DONE cycle (one cycle after the last accepted column) and return to IDLE on the next edge.
REQ-022 SHALL hold energy_out unchanged outside the DONE load until the next completed evaluation.
REQ-023 SHALL ignore dot_valid in IDLE and DONE.
REQ-024 SHALL give start priority over a simultaneous dot_valid: that column is discarded, a new evaluation begins, and no energy_valid follows from the aborted one.
REQ-025 SHALL, on start during ACC, abort the evaluation without asserting energy_valid.
REQ-026 SHALL use only the latched sigma; changes on the sigma input after start do not affect the result.

Reset
REQ-027 SHALL, while rst_n=0, force state IDLE, busy=0, energy_valid=0, col_idx=0, energy_out=0, accumulator=0 and the sigma register=0, independent of clk.
REQ-028 SHALL, on reset asserted mid-evaluation, discard the partial sum; the first start after release produces a correct result.

Verification
REQ-029 SHALL pass: sigma all 1, start, 256 dot_valid with dot_in=10 -> energy_out=2560, energy_valid one cycle after the 256th column.
REQ-030 SHALL pass: sigma all 0, dot_in=10 x256 -> -2560; sigma bit i=i%2, dot_in=5 x256 -> 0.
REQ-031 SHALL pass: sigma all 1, dot_in=3840 x256 -> 983040; sigma all 0, dot_in=-3840 x256 -> 983040 (no overflow).
REQ-032 SHALL pass: dot_valid every 3rd cycle, random sigma and dot_in -> matches the model; busy high throughout; exactly one energy_valid pulse.
REQ-033 SHALL pass: start again after 50 columns, then 256 columns of 1 with sigma all 1 -> single energy_valid with 256; a start coincident with the 256th column gives no pulse.
REQ-034 SHALL pass: rst_n low after 100 columns -> all outputs 0 immediately; a subsequent full run is correct.

Source files
------------

// File: rtl/energy_accumulator.sv
// energy_accumulator: signed sum of column dot products, each weighted by the latched spin (+1/-1)
module energy_accumulator #(
    parameter int VECTOR_SIZE     = 256,
    parameter int J_ELEMENT_WIDTH = 4,
    parameter int DOT_WIDTH       = J_ELEMENT_WIDTH + $clog2(VECTOR_SIZE) + 1,
    parameter int ACC_WIDTH       = DOT_WIDTH + $clog2(VECTOR_SIZE)
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 start,
    input  logic [VECTOR_SIZE-1:0]               sigma,
    input  logic                                 dot_valid,
    input  logic signed [DOT_WIDTH-1:0]          dot_in,
    output logic [$clog2(VECTOR_SIZE)-1:0]       col_idx,
    output logic                                 busy,
    output logic signed [ACC_WIDTH-1:0]          energy_out,
    output logic                                 energy_valid
);
    localparam int IW = $clog2(VECTOR_SIZE);
    typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;
    state_t                        state_q;
    logic [VECTOR_SIZE-1:0]        sigma_q;
    logic signed [ACC_WIDTH-1:0]   acc_q, acc_d, energy_q;
    logic [IW-1:0]                 col_q;
    logic                          busy_q, valid_q;
    logic signed [ACC_WIDTH-1:0]   dot_ext;
    // next running sum: sign-extended column term added for spin +1, subtracted for spin -1
    always_comb begin
        dot_ext = {{(ACC_WIDTH-DOT_WIDTH){dot_in[DOT_WIDTH-1]}}, dot_in};
        acc_d   = sigma_q[col_q] ? acc_q + dot_ext : acc_q - dot_ext;
    end
    // control FSM; start wins over everything else and silently aborts any evaluation in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            sigma_q  <= '0;
            acc_q    <= '0;
            col_q    <= '0;
            energy_q <= '0;
            busy_q   <= 1'b0;
            valid_q  <= 1'b0;
        end else if (start) begin
            state_q <= ACC;
            sigma_q <= sigma;
            acc_q   <= '0;
            col_q   <= '0;
            busy_q  <= 1'b1;
            valid_q <= 1'b0;
        end else begin
            case (state_q)
                ACC: if (dot_valid) begin
                    acc_q <= acc_d;
                    if (col_q == IW'(VECTOR_SIZE - 1)) begin
                        col_q    <= '0;
                        energy_q <= acc_d;
                        state_q  <= DONE;
                        busy_q   <= 1'b0;
                        valid_q  <= 1'b1;
                    end else begin
                        col_q <= col_q + 1'b1;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    valid_q <= 1'b0;
                end
                default: ;
            endcase
        end
    end
    assign col_idx      = col_q;
    assign busy         = busy_q;
    assign energy_out   = energy_q;
    assign energy_valid = valid_q;
endmodule

// File: tb/tb_energy_accumulator.sv
// tb_energy_accumulator: directed vector table plus hand-written abort/reset sequences
module tb_energy_accumulator;
    logic                clk = 1'b0, rst_n = 1'b0, start = 1'b0, dot_valid = 1'b0;
    logic [255:0]        sigma = '0;
    logic signed [12:0]  dot_in = '0;
    logic [7:0]          col_idx;
    logic                busy, energy_valid;
    logic signed [20:0]  energy_out;
    int                  tests = 0, fails = 0, pulses = 0;
    logic signed [12:0]  dots [256];
    typedef struct {
        string        name;
        logic [255:0] s;
        int           dot;
        int           gap;
        int           exp;
    } vec_t;
    vec_t vecs [6];

    energy_accumulator dut (
        .clk(clk), .rst_n(rst_n), .start(start), .sigma(sigma),
        .dot_valid(dot_valid), .dot_in(dot_in), .col_idx(col_idx),
        .busy(busy), .energy_out(energy_out), .energy_valid(energy_valid)
    );

    always #5 clk = ~clk;
    always @(posedge clk) if (energy_valid) pulses++;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1);
    end

    task automatic chk(input string n, input longint got, input longint exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0d required %0d", n, got, exp);
        end
    endtask

    task automatic fill(input int v);
        for (int i = 0; i < 256; i++) dots[i] = 13'(v);
    endtask

    function automatic logic signed [20:0] model(input logic [255:0] s);
        logic signed [20:0] m;
        m = '0;
        for (int i = 0; i < 256; i++) m = s[i] ? m + dots[i] : m - dots[i];
        return m;
    endfunction

    task automatic feed(input int n);
        for (int i = 0; i < n; i++) begin
            dot_valid = 1'b1; dot_in = dots[i];
            @(negedge clk);
            dot_valid = 1'b0;
        end
    endtask

    task automatic run(input string n, input logic [255:0] s, input int gap, input int exp);
        int p0;
        int bb;
        p0 = pulses;
        bb = 0;
        start = 1'b1; sigma = s;
        @(negedge clk);
        start = 1'b0; sigma = ~s;
        for (int i = 0; i < 256; i++) begin
            repeat (gap) begin
                if (!busy) bb++;
                @(negedge clk);
            end
            if (!busy) bb++;
            dot_valid = 1'b1; dot_in = dots[i];
            @(negedge clk);
            dot_valid = 1'b0;
        end
        chk({n, " valid"}, energy_valid, 1);
        chk({n, " energy"}, energy_out, exp);
        chk({n, " busy low cycles"}, bb, 0);
        @(negedge clk);
        chk({n, " hold"}, energy_out, exp);
        chk({n, " pulses"}, pulses - p0, 1);
        chk({n, " idle busy/valid"}, {busy, energy_valid}, 0);
    endtask

    initial begin
        logic [255:0] alt, all1, rs;
        int p0;
        all1 = {256{1'b1}};
        for (int i = 0; i < 256; i++) alt[i] = i[0];
        vecs[0] = '{"all1 x10",      all1,    10,    0, 2560};
        vecs[1] = '{"all0 x10",      '0,      10,    0, -2560};
        vecs[2] = '{"alt x5",        alt,     5,     0, 0};
        vecs[3] = '{"all1 x3840",    all1,    3840,  0, 983040};
        vecs[4] = '{"all0 x-3840",   '0,      -3840, 0, 983040};
        vecs[5] = '{"all1 x-7 gap1", all1,    -7,    1, -1792};
        #12;
        chk("reset outputs", {col_idx, busy, energy_valid, energy_out}, 0);
        @(negedge clk) rst_n = 1'b1;
        @(negedge clk);
        for (int v = 0; v < 6; v++) begin
            fill(vecs[v].dot);
            run(vecs[v].name, vecs[v].s, vecs[v].gap, vecs[v].exp);
        end
        // dot_valid while idle must not move anything
        p0 = pulses;
        dot_valid = 1'b1; dot_in = 13'sd100;
        repeat (3) @(negedge clk);
        dot_valid = 1'b0;
        @(negedge clk);
        chk("idle ignore col_idx", col_idx, 0);
        chk("idle ignore energy", energy_out, -1792);
        chk("idle ignore pulses", pulses - p0, 0);
        // every third cycle, random spins and dot products
        for (int i = 0; i < 256; i++) dots[i] = 13'($urandom_range(0, 7680) - 3840);
        rs = {8{$urandom}};
        run("random gap2", rs, 2, model(rs));
        // restart after 50 columns
        fill(1);
        p0 = pulses;
        start = 1'b1; sigma = all1;
        @(negedge clk);
        start = 1'b0;
        feed(50);
        chk("col_idx after 50", col_idx, 50);
        run("restart", all1, 0, 256);
        chk("restart single pulse", pulses - p0, 1);
        // start coincident with the last column
        p0 = pulses;
        start = 1'b1; sigma = all1;
        @(negedge clk);
        start = 1'b0;
        feed(255);
        chk("col_idx at 255", col_idx, 255);
        dot_valid = 1'b1; start = 1'b1;
        @(negedge clk);
        dot_valid = 1'b0; start = 1'b0;
        chk("coincident no valid", energy_valid, 0);
        chk("coincident busy", busy, 1);
        chk("coincident col_idx", col_idx, 0);
        @(negedge clk);
        chk("coincident no pulse", pulses - p0, 0);
        chk("coincident energy held", energy_out, 256);
        // asynchronous reset mid-evaluation
        fill(10);
        start = 1'b1; sigma = all1;
        @(negedge clk);
        start = 1'b0;
        feed(100);
        chk("col_idx at 100", col_idx, 100);
        #2 rst_n = 1'b0;
        #1;
        chk("async reset col_idx", col_idx, 0);
        chk("async reset busy", busy, 0);
        chk("async reset valid", energy_valid, 0);
        chk("async reset energy", energy_out, 0);
        @(negedge clk) rst_n = 1'b1;
        @(negedge clk);
        run("after reset", all1, 0, 2560);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
